// File: rtl/ps2_mouse_regbank.sv
// PS/2 mouse register bank: accumulates packet motion into clamped positions,
// scales positions on bus access, queues raw packets and raises an interrupt.
module ps2_mouse_regbank #(
  parameter int POS_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8,
  parameter int CLAMP_EN   = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PktValid,
  input  logic [2:0]        PktBtn,
  input  logic [8:0]        PktDX,
  input  logic [8:0]        PktDY,
  input  logic              PktNoAck,
  input  logic [ADDR_W-1:0] RdAddr,
  input  logic              RdEn,
  output logic [POS_W-1:0]  RdData,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [POS_W-1:0]  WrData,
  input  logic              WrEn,
  output logic              ENoReadReg,
  output logic              ENoWriteReg,
  output logic              Irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PKT_W = 21;

  localparam logic [ADDR_W-1:0] A_POS_X   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_POS_Y   = ADDR_W'(8'h01);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(8'h02);
  localparam logic [ADDR_W-1:0] A_SCALE_X = ADDR_W'(8'h03);
  localparam logic [ADDR_W-1:0] A_SCALE_Y = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_MIN_X   = ADDR_W'(8'h05);
  localparam logic [ADDR_W-1:0] A_MAX_X   = ADDR_W'(8'h06);
  localparam logic [ADDR_W-1:0] A_MIN_Y   = ADDR_W'(8'h07);
  localparam logic [ADDR_W-1:0] A_MAX_Y   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_FIFO    = ADDR_W'(8'h09);
  localparam logic [ADDR_W-1:0] A_LEVEL   = ADDR_W'(8'h0A);

  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};

  logic signed [POS_W-1:0] pos_x, pos_y;
  logic signed [POS_W-1:0] min_x, max_x, min_y, max_y;
  logic [5:0]              scale_x, scale_y;
  logic [4:0]              st_last;
  logic                    st_ovf, st_clamp;
  logic [15:0]             pkt_cnt;
  logic [PKT_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]          wr_ptr, rd_ptr;

  // Packet step: returns {saturated, new_position}. The sum is formed one bit
  // wider than the accumulator so the window compare can never overflow.
  function automatic logic [POS_W:0] pkt_step(input logic signed [POS_W-1:0] pos,
                                               input logic [8:0] d,
                                               input logic signed [POS_W-1:0] mn,
                                               input logic signed [POS_W-1:0] mx);
    logic signed [POS_W:0] sum, lo, hi;
    logic [POS_W:0]        r;
    sum = {pos[POS_W-1], pos} + {{(POS_W-8){d[8]}}, d};
    lo  = {mn[POS_W-1], mn};
    hi  = {mx[POS_W-1], mx};
    if (CLAMP_EN == 0)  r = {1'b0, sum[POS_W-1:0]};
    else if (lo > hi)   r = {1'b1, mn};
    else if (sum < lo)  r = {1'b1, mn};
    else if (sum > hi)  r = {1'b1, mx};
    else                r = {1'b0, sum[POS_W-1:0]};
    return r;
  endfunction

  // Bus writes go through the inverse of the read scaling, then the window.
  function automatic logic signed [POS_W-1:0] wr_scale(input logic [POS_W-1:0] d,
                                                       input logic [5:0] sc);
    if (sc[5]) return d << sc[4:0];
    else       return $signed(d) >>> sc[4:0];
  endfunction

  function automatic logic signed [POS_W-1:0] rd_scale(input logic signed [POS_W-1:0] p,
                                                       input logic [5:0] sc);
    if (sc[5]) return p >>> sc[4:0];
    else       return p << sc[4:0];
  endfunction

  function automatic logic signed [POS_W-1:0] wr_clamp(input logic signed [POS_W-1:0] v,
                                                       input logic signed [POS_W-1:0] mn,
                                                       input logic signed [POS_W-1:0] mx);
    if (CLAMP_EN == 0) return v;
    else if (mn > mx)  return mn;
    else if (v < mn)   return mn;
    else if (v > mx)   return mx;
    else               return v;
  endfunction

  logic                    wr_pos_x, wr_pos_y, wr_status;
  logic [POS_W:0]          step_x, step_y;
  logic signed [POS_W-1:0] wr_val_x, wr_val_y;
  logic [PTR_W:0]          fifo_count, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic                    fifo_empty, fifo_full, pop, push_ok, ovf_set;
  logic                    clamp_set, ovf_nxt, clamp_nxt, irq_nxt;

  // Write decode, position update candidates, FIFO and sticky next-state.
  always_comb begin
    wr_pos_x   = WrEn && (WrAddr == A_POS_X);
    wr_pos_y   = WrEn && (WrAddr == A_POS_Y);
    wr_status  = WrEn && (WrAddr == A_STATUS);
    step_x     = pkt_step(pos_x, PktDX, min_x, max_x);
    step_y     = pkt_step(pos_y, PktDY, min_y, max_y);
    wr_val_x   = wr_clamp(wr_scale(WrData, scale_x), min_x, max_x);
    wr_val_y   = wr_clamp(wr_scale(WrData, scale_y), min_y, max_y);
    fifo_count = wr_ptr - rd_ptr;
    fifo_empty = (fifo_count == '0);
    fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    pop        = RdEn && (RdAddr == A_FIFO) && !fifo_empty;
    push_ok    = PktValid && (!fifo_full || pop);
    ovf_set    = PktValid && fifo_full && !pop;
    clamp_set  = PktValid && ((step_x[POS_W] && !wr_pos_x) || (step_y[POS_W] && !wr_pos_y));
    wr_ptr_nxt = wr_ptr + (PTR_W+1)'(push_ok);
    rd_ptr_nxt = rd_ptr + (PTR_W+1)'(pop);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    ovf_nxt    = ovf_set   || (st_ovf   && !(wr_status && WrData[6]));
    clamp_nxt  = clamp_set || (st_clamp && !(wr_status && WrData[7]));
    irq_nxt    = (count_nxt != '0) || ovf_nxt || clamp_nxt;
  end

  // Position accumulators: a bus write to an axis overrides that axis' packet.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pos_x <= '0;
      pos_y <= '0;
    end else begin
      if (wr_pos_x)      pos_x <= wr_val_x;
      else if (PktValid) pos_x <= step_x[POS_W-1:0];
      if (wr_pos_y)      pos_y <= wr_val_y;
      else if (PktValid) pos_y <= step_y[POS_W-1:0];
    end
  end

  // Configuration registers: scale and clamp window.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scale_x <= '0;
      scale_y <= '0;
      min_x   <= POS_MIN;
      max_x   <= POS_MAX;
      min_y   <= POS_MIN;
      max_y   <= POS_MAX;
    end else if (WrEn) begin
      case (WrAddr)
        A_SCALE_X: scale_x <= WrData[5:0];
        A_SCALE_Y: scale_y <= WrData[5:0];
        A_MIN_X:   min_x   <= WrData;
        A_MAX_X:   max_x   <= WrData;
        A_MIN_Y:   min_y   <= WrData;
        A_MAX_Y:   max_y   <= WrData;
        default:   ;
      endcase
    end
  end

  // Status, sticky flags, packet counter and the registered interrupt.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st_last  <= '0;
      st_ovf   <= 1'b0;
      st_clamp <= 1'b0;
      pkt_cnt  <= '0;
      Irq      <= 1'b0;
    end else begin
      if (PktValid) begin
        st_last <= {PktDY[8], PktDX[8], PktBtn};
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      st_ovf   <= ovf_nxt;
      st_clamp <= clamp_nxt;
      Irq      <= irq_nxt;
    end
  end

  // Packet FIFO; a full FIFO still accepts a push when the head is popped.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push_ok) fifo_mem[wr_ptr[PTR_W-1:0]] <= {PktBtn, PktDX, PktDY};
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Read mux and access error flags.
  always_comb begin
    RdData = '0;
    case (RdAddr)
      A_POS_X:   RdData = rd_scale(pos_x, scale_x);
      A_POS_Y:   RdData = rd_scale(pos_y, scale_y);
      A_STATUS:  RdData = POS_W'({!fifo_empty, st_clamp, st_ovf, PktNoAck, st_last});
      A_SCALE_X: RdData = POS_W'(scale_x);
      A_SCALE_Y: RdData = POS_W'(scale_y);
      A_MIN_X:   RdData = min_x;
      A_MAX_X:   RdData = max_x;
      A_MIN_Y:   RdData = min_y;
      A_MAX_Y:   RdData = max_y;
      A_FIFO:    RdData = fifo_empty ? '0 : POS_W'(fifo_mem[rd_ptr[PTR_W-1:0]]);
      A_LEVEL:   RdData = POS_W'({pkt_cnt, 16'(fifo_count)});
      default:   RdData = '0;
    endcase
    ENoReadReg  = (RdAddr > A_LEVEL);
    ENoWriteReg = (WrAddr > A_LEVEL) || (WrAddr == A_FIFO) || (WrAddr == A_LEVEL);
  end

endmodule

// File: tb/tb_ps2_mouse_regbank.sv
// Directed bench for ps2_mouse_regbank with hand-computed expectations.
`timescale 1ns/1ps
module tb_ps2_mouse_regbank;

  logic        Clk = 1'b0;
  logic        Reset, PktValid, PktNoAck, RdEn, WrEn;
  logic [2:0]  PktBtn;
  logic [8:0]  PktDX, PktDY;
  logic [7:0]  RdAddr, WrAddr;
  logic [31:0] RdData, WrData;
  logic        ENoReadReg, ENoWriteReg, Irq;

  int n_cmp = 0;
  int n_err = 0;

  ps2_mouse_regbank #(.POS_W(32), .FIFO_DEPTH(4), .ADDR_W(8), .CLAMP_EN(1)) dut (
    .Clk(Clk), .Reset(Reset), .PktValid(PktValid), .PktBtn(PktBtn), .PktDX(PktDX),
    .PktDY(PktDY), .PktNoAck(PktNoAck), .RdAddr(RdAddr), .RdEn(RdEn), .RdData(RdData),
    .WrAddr(WrAddr), .WrData(WrData), .WrEn(WrEn), .ENoReadReg(ENoReadReg),
    .ENoWriteReg(ENoWriteReg), .Irq(Irq)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    @(negedge Clk);
    RdAddr = a;
    #1;
    chk(tag, RdData, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    @(negedge Clk);
    chk(tag, {31'b0, Irq}, {31'b0, exp});
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge Clk);
    WrAddr = a; WrData = d; WrEn = 1'b1;
    @(posedge Clk); #1;
    WrEn = 1'b0;
  endtask

  task automatic pkt(input logic [2:0] b, input logic [8:0] dx, input logic [8:0] dy);
    @(negedge Clk);
    PktBtn = b; PktDX = dx; PktDY = dy; PktValid = 1'b1;
    @(posedge Clk); #1;
    PktValid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    @(negedge Clk);
    RdAddr = 8'h09;
    #1;
    chk(tag, RdData, exp);
    RdEn = 1'b1;
    @(posedge Clk); #1;
    RdEn = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; PktValid = 1'b0; PktNoAck = 1'b0; RdEn = 1'b0; WrEn = 1'b0;
    PktBtn = '0; PktDX = '0; PktDY = '0; RdAddr = '0; WrAddr = '0; WrData = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk); Reset = 1'b0;

    // Reset state
    chk_rd("rst_pos_x",  8'h00, 32'h0);
    chk_rd("rst_pos_y",  8'h01, 32'h0);
    chk_rd("rst_status", 8'h02, 32'h0);
    chk_rd("rst_scale",  8'h03, 32'h0);
    chk_rd("rst_min_x",  8'h05, 32'h8000_0000);
    chk_rd("rst_max_x",  8'h06, 32'h7FFF_FFFF);
    chk_rd("rst_min_y",  8'h07, 32'h8000_0000);
    chk_rd("rst_max_y",  8'h08, 32'h7FFF_FFFF);
    chk_rd("rst_fifo",   8'h09, 32'h0);
    chk_rd("rst_level",  8'h0A, 32'h0);
    chk("rst_enoread_0a", {31'b0, ENoReadReg}, 32'h0);
    chk_rd("unmapped",   8'h20, 32'h0);
    chk("enoread_20", {31'b0, ENoReadReg}, 32'h1);
    chk_irq("rst_irq", 1'b0);

    // Accumulation and FIFO ordering
    pkt(3'd1, 9'd5, 9'd0);
    pkt(3'd0, 9'd5, 9'd0);
    pkt(3'd2, 9'h1FD, 9'd0);
    chk_rd("acc_pos_x",  8'h00, 32'd7);
    chk_rd("acc_level",  8'h0A, 32'h0003_0003);
    chk_rd("acc_status", 8'h02, 32'h0000_010A);
    chk_irq("acc_irq", 1'b1);
    pop_chk("pop1", 32'h0004_0A00);
    pop_chk("pop2", 32'h0000_0A00);
    pop_chk("pop3", 32'h000B_FA00);
    pop_chk("pop_empty", 32'h0);
    chk_rd("drain_level", 8'h0A, 32'h0003_0000);
    chk_irq("drain_irq", 1'b0);

    // Clamp to window maximum, sticky CLAMP and W1C
    wr(8'h06, 32'd10);
    wr(8'h00, 32'd8);
    pkt(3'd0, 9'd100, 9'd0);
    chk_rd("clamp_pos_x",  8'h00, 32'd10);
    chk_rd("clamp_status", 8'h02, 32'h0000_0180);
    pop_chk("clamp_pop", 32'h0000_C800);
    chk_irq("clamp_irq", 1'b1);
    wr(8'h02, 32'h80);
    chk_rd("w1c_status", 8'h02, 32'h0);
    chk_irq("w1c_irq", 1'b0);
    wr(8'h06, 32'h7FFF_FFFF);

    // Scaling on write and read
    wr(8'h03, 32'h22);
    chk_rd("scale_rb", 8'h03, 32'h22);
    wr(8'h00, 32'd12);
    chk_rd("scale_rd_div", 8'h00, 32'd12);
    wr(8'h03, 32'h02);
    chk_rd("scale_rd_mul", 8'h00, 32'd192);
    wr(8'h03, 32'h00);
    chk_rd("scale_raw", 8'h00, 32'd48);

    // FIFO overflow and push+pop when full, from a fresh reset
    @(negedge Clk); Reset = 1'b1; #2; Reset = 1'b0;
    pkt(3'd0, 9'd1, 9'd0);
    pkt(3'd0, 9'd2, 9'd0);
    pkt(3'd0, 9'd3, 9'd0);
    pkt(3'd0, 9'd4, 9'd0);
    pkt(3'd0, 9'd5, 9'd0);
    chk_rd("ovf_level",  8'h0A, 32'h0005_0004);
    chk_rd("ovf_status", 8'h02, 32'h0000_0140);
    chk_rd("ovf_pos_x",  8'h00, 32'd15);
    wr(8'h02, 32'h40);
    @(negedge Clk);
    RdAddr = 8'h09; RdEn = 1'b1;
    PktBtn = '0; PktDX = 9'd6; PktDY = '0; PktValid = 1'b1;
    @(posedge Clk); #1;
    RdEn = 1'b0; PktValid = 1'b0;
    chk_rd("pp_level",  8'h0A, 32'h0006_0004);
    chk_rd("pp_status", 8'h02, 32'h0000_0100);
    chk_rd("pp_pos_x",  8'h00, 32'd21);
    pop_chk("pp_pop1", 32'h0000_0400);
    pop_chk("pp_pop2", 32'h0000_0600);
    pop_chk("pp_pop3", 32'h0000_0800);
    pop_chk("pp_pop4", 32'h0000_0C00);
    chk_rd("pp_empty", 8'h09, 32'h0);
    chk_irq("pp_irq", 1'b0);

    // Bus write beats a simultaneous packet on the same axis
    @(negedge Clk);
    WrAddr = 8'h01; WrData = 32'd100; WrEn = 1'b1;
    PktBtn = '0; PktDX = '0; PktDY = 9'd1; PktValid = 1'b1;
    @(posedge Clk); #1;
    WrEn = 1'b0; PktValid = 1'b0;
    chk_rd("wrwin_pos_y", 8'h01, 32'd100);
    chk_rd("wrwin_level", 8'h0A, 32'h0007_0001);
    chk_rd("wrwin_fifo",  8'h09, 32'h0000_0001);
    PktNoAck = 1'b1;
    chk_rd("noack_status", 8'h02, 32'h0000_0120);
    PktNoAck = 1'b0;

    // Write-error decode and ignored writes
    @(negedge Clk); WrAddr = 8'h09; #1;
    chk("enowr_09", {31'b0, ENoWriteReg}, 32'h1);
    WrAddr = 8'h0A; #1;
    chk("enowr_0a", {31'b0, ENoWriteReg}, 32'h1);
    WrAddr = 8'h0B; #1;
    chk("enowr_0b", {31'b0, ENoWriteReg}, 32'h1);
    WrAddr = 8'h08; #1;
    chk("enowr_08", {31'b0, ENoWriteReg}, 32'h0);
    wr(8'h09, 32'hFFFF_FFFF);
    wr(8'h0A, 32'hFFFF_FFFF);
    chk_rd("rowr_fifo",  8'h09, 32'h0000_0001);
    chk_rd("rowr_level", 8'h0A, 32'h0007_0001);

    // Inverted window forces MIN; negative lower bound
    wr(8'h05, 32'd20);
    wr(8'h06, 32'd10);
    pkt(3'd0, 9'd1, 9'd0);
    chk_rd("inv_pos_x",  8'h00, 32'd20);
    chk_rd("inv_status", 8'h02, 32'h0000_0180);
    wr(8'h05, 32'hFFFF_FFFD);
    wr(8'h00, 32'd0);
    pkt(3'd0, 9'h1FB, 9'd0);
    chk_rd("neg_pos_x", 8'h00, 32'hFFFF_FFFD);

    // Reset in the middle of a packet burst
    @(negedge Clk);
    PktBtn = 3'd7; PktDX = 9'd3; PktDY = 9'd3; PktValid = 1'b1;
    repeat (3) @(posedge Clk);
    #1; Reset = 1'b1; PktValid = 1'b0;
    chk_rd("midrst_level", 8'h0A, 32'h0);
    @(negedge Clk); Reset = 1'b0;
    chk_rd("post_pos_x",  8'h00, 32'h0);
    chk_rd("post_pos_y",  8'h01, 32'h0);
    chk_rd("post_status", 8'h02, 32'h0);
    chk_rd("post_level",  8'h0A, 32'h0);
    chk_rd("post_fifo",   8'h09, 32'h0);
    chk_rd("post_min_x",  8'h05, 32'h8000_0000);
    chk_irq("post_irq", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
